// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage of the 5-stage MIPS pipeline.
// mult/multu/div/divu compute their result when start is accepted, park it in tmp_hi/tmp_lo,
// and commit it to HI/LO after a fixed busy window. mthi/mtlo write HI/LO in one cycle.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        div_b, q_u, r_u;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag, q_s, r_s;

    // Datapath: full 64-bit products and both flavours of quotient/remainder.
    // Signed division goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // with remainder 0 instead of hitting an overflow trap; the divisor is forced
    // nonzero so the divide-by-zero path never evaluates x/0.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'b0, A} * {32'b0, B};
        div_b  = (B == 32'd0) ? 32'd1 : B;
        q_u    = A / div_b;
        r_u    = A % div_b;
        a_mag  = A[31] ? (~A + 32'd1) : A;
        b_mag  = div_b[31] ? (~div_b + 32'd1) : div_b;
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        q_s    = (A[31] ^ div_b[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
    end

    // State register: reset discards any in-flight result immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
        end
    end

    // Next state: accept ops only while idle; count down and commit while busy.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {tmp_hi_d, tmp_lo_d} = prod_s;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MULTU: begin
                            {tmp_hi_d, tmp_lo_d} = prod_u;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still occupies the full window but
                            // commits the current HI/LO back, leaving them unchanged.
                            if (B == 32'd0) begin
                                tmp_hi_d = hi_q;
                                tmp_lo_d = lo_q;
                            end else if (op == OP_DIV) begin
                                tmp_hi_d = r_s;
                                tmp_lo_d = q_s;
                            end else begin
                                tmp_hi_d = r_u;
                                tmp_lo_d = q_u;
                            end
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // start is ignored here, including on the completion edge.
                if (cnt_q <= CNT_W'(1)) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: md_stall flags an md-class start in the same cycle, before busy rises.
    always_comb begin
        busy     = (state_q == S_BUSY);
        md_stall = busy | (start & ~op[2]);
        HI       = hi_q;
        LO       = lo_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table driven through a scoreboard queue, plus
// hand-written sequences for reset mid-op, start during busy and back-to-back ops.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, md_stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi, m_lo;
    vec_t        vecs[17];

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .md_stall(md_stall), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Drive one start pulse from a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string nm);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1 chk({nm, " md_stall"}, {31'b0, md_stall}, (o <= 3'd3) ? 32'd1 : 32'd0);
        @(negedge clk);
        start = 1'b0; op = 3'd6;
    endtask

    // Count busy cycles (pre already elapsed), check HI/LO hold, then pop and compare.
    task automatic finish_op(input string nm, input int pre);
        exp_t e;
        int   cnt;
        cnt = pre;
        while (busy === 1'b1 && cnt < 40) begin
            chk({nm, " hold HI"}, hi, m_hi);
            chk({nm, " hold LO"}, lo, m_lo);
            cnt++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, " busy cycles"}, 32'(cnt), 32'(e.n));
            chk({nm, " HI"}, hi, e.hi);
            chk({nm, " LO"}, lo, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    initial begin
        exp_t e;
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd4, 32'h11111111, 32'h00000000, 32'h11111111, 32'h80000000, 0};
        vecs[6]  = '{3'd5, 32'h22222222, 32'h00000000, 32'h11111111, 32'h22222222, 0};
        vecs[7]  = '{3'd2, 32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 10};
        vecs[8]  = '{3'd3, 32'h00000009, 32'h00000000, 32'h11111111, 32'h22222222, 10};
        vecs[9]  = '{3'd6, 32'h0000DEAD, 32'h00000001, 32'h11111111, 32'h22222222, 0};
        vecs[10] = '{3'd7, 32'h0000BEEF, 32'h00000001, 32'h11111111, 32'h22222222, 0};
        vecs[11] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[12] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[13] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[14] = '{3'd2, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 10};
        vecs[15] = '{3'd3, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10};
        vecs[16] = '{3'd2, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 10};

        rst_n = 1'b0; start = 1'b0; op = 3'd6; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset HI", hi, 32'd0);
        chk("reset LO", lo, 32'd0);
        chk("reset md_stall", {31'b0, md_stall}, 32'd0);

        // Preload, then reset in the middle of a mult (counter at 3).
        sb.push_back('{32'hAAAAAAAA, 32'h00000000, 0});
        issue(3'd4, 32'hAAAAAAAA, 32'd0, "pre mthi");
        finish_op("pre mthi", 0);
        sb.push_back('{32'hAAAAAAAA, 32'h5555AAAA, 0});
        issue(3'd5, 32'h5555AAAA, 32'd0, "pre mtlo");
        finish_op("pre mtlo", 0);
        issue(3'd0, 32'd3, 32'd3, "rst mult");
        repeat (2) @(negedge clk);
        chk("rst mult busy before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst busy", {31'b0, busy}, 32'd0);
        chk("async rst HI", hi, 32'd0);
        chk("async rst LO", lo, 32'd0);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post rst busy", {31'b0, busy}, 32'd0);
        chk("post rst HI", hi, 32'd0);
        chk("post rst LO", lo, 32'd0);
        m_hi = '0; m_lo = '0;

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < 17; i++) begin
            string nm;
            nm = $sformatf("vec%0d op%0d", i, vecs[i].op);
            sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].n});
            issue(vecs[i].op, vecs[i].a, vecs[i].b, nm);
            finish_op(nm, 0);
        end

        // mtlo pulsed mid-divide must be ignored.
        sb.push_back('{32'd2, 32'd14, 10});
        issue(3'd3, 32'd100, 32'd7, "busy divu");
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'h0000DEAD; b = '0;
        #1 chk("busy mtlo md_stall", {31'b0, md_stall}, 32'd1);
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        finish_op("busy divu", 3);

        // Start presented on the completion edge is ignored, accepted one edge later.
        sb.push_back('{32'd0, 32'd6, 5});
        issue(3'd0, 32'd2, 32'd3, "b2b first");
        repeat (4) @(negedge clk);
        chk("b2b busy at last cycle", {31'b0, busy}, 32'd1);
        start = 1'b1; op = 3'd0; a = 32'd4; b = 32'd5;
        #1 chk("b2b md_stall busy", {31'b0, md_stall}, 32'd1);
        @(negedge clk);
        chk("b2b ignored busy", {31'b0, busy}, 32'd0);
        chk("b2b idle md_stall", {31'b0, md_stall}, 32'd1);
        e = sb.pop_front();
        chk("b2b first HI", hi, e.hi);
        chk("b2b first LO", lo, e.lo);
        m_hi = e.hi; m_lo = e.lo;
        sb.push_back('{32'd0, 32'd20, 5});
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        chk("b2b accepted busy", {31'b0, busy}, 32'd1);
        finish_op("b2b second", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu with fixed multi-cycle latency, and mthi/mtlo in a single cycle.
- Exposes HI/LO for mfhi/mflo. These values travel through ex_mem into the ALUout path of the memory/writeback registers.
- Drives busy/stall hints to the hazard unit, which freezes the pipeline on a md-class instruction while the unit is occupied.

Parameters:
MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1)
DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  E-stage md instruction valid this cycle
op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
A  in  32  rs operand (forwarded)
B  in  32  rt operand (forwarded)
busy  out  1  multi-cycle operation in progress (registered)
md_stall  out  1  combinational: busy | (start & op<=3)
HI  out  32  HI register
LO  out  32  LO register

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, busy=0, counter=0, internal result regs=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- State machine:
  - IDLE (busy=0): at a rising edge with start=1:
    - op 0-3: latch result into tmp_hi/tmp_lo, load counter with MULT_CYCLES or DIV_CYCLES, go BUSY.
    - op 4: HI<=A, stay IDLE.
    - op 5: LO<=A, stay IDLE.
    - op 6/7: nothing.
  - BUSY (busy=1): decrement counter each edge. At the edge where counter==1: HI<=tmp_hi, LO<=tmp_lo, busy<=0, go IDLE.
- Latency: start sampled at edge E0 -> busy=1 for exactly N cycles after E0 -> HI/LO visible and busy=0 after edge E0+N. N=5 for mult, N=10 for div.
- start while BUSY: ignored entirely, including mthi/mtlo. The hazard unit guarantees this never happens legally; the bench checks that HI/LO are not corrupted.
- HI/LO stay stable during BUSY and show the previous values. mfhi/mflo are stalled by the hazard unit via busy.
- Arithmetic:
  - mult: {HI,LO} = signed A * signed B, 64-bit.
  - multu: {HI,LO} = unsigned product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 div 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (B==0, div or divu): busy runs the full DIV_CYCLES; HI/LO are left unchanged at completion.
- md_stall is purely combinational. It is high in the start cycle of ops 0-3 so the following instruction in D can stall without waiting a cycle.
- Completion edge and a new start at the same edge: the start is ignored, because busy is still 1 at that edge. A new op is accepted from the next edge.

Test Plan:
- Reset test: hold reset=0 mid-mult (counter=3) -> busy, HI and LO drop to 0 immediately without a clock edge. Release reset, then 6 idle cycles -> HI=LO=0.
- mult test:
  - Stimulus: mult A=0xFFFFFFFE (-2), B=3, start 1 cycle.
  - Response: busy=1 for exactly 5 cycles with HI/LO unchanged; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div test:
  - div A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 -> LO=3, HI=1.
  - div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11111111 and LO=0x22222222 via mthi/mtlo (each visible after 1 edge, busy stays 0). Then div A=5, B=0 -> busy 10 cycles, HI/LO unchanged.
- Start during busy: divu A=100, B=7, then pulse mtlo A=0xDEAD at busy cycle 4 -> ignored; final LO=14, HI=2.
- md_stall and back-to-back ops:
  - md_stall=1 in the start cycle of mult and 0 for mthi.
  - Start a new mult at the completion edge -> ignored.
  - Start at the next edge -> accepted; busy re-asserts for 5 cycles.
